// File: rtl/paddle_engine.sv
// paddle_engine: paddle sprite engine for the 160x120 VGA adapter.
// Generates its own frame tick, moves a PAD_W x PAD_H paddle on button
// requests, and repaints it pixel by pixel (erase old, draw new).
// Optional build macro: PADDLE_ACCEL_EN enables step acceleration.
module paddle_engine #(
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned PAD_W     = 16,
  parameter int unsigned PAD_H     = 2,
  parameter int unsigned X_INIT    = 72,
  parameter int unsigned Y_POS     = 110,
  parameter int unsigned STEP      = 1,
  parameter int unsigned MAX_STEP  = 4,
  parameter int unsigned FRAME_DIV = 833334,
  parameter logic [2:0]  FG_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       left,
  input  logic       right,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic [7:0] pad_x,
  output logic       busy,
  output logic       frame_tick
);

  localparam int unsigned     DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(FRAME_DIV - 1);
  localparam logic [8:0]      X_MAX    = 9'(SCREEN_W - PAD_W);
  localparam logic [7:0]      COL_LAST = 8'(PAD_W - 1);
  localparam logic [2:0]      ROW_LAST = 3'(PAD_H - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ERASE, S_MOVE, S_DRAW} state_t;

  state_t           state, state_d;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       col, col_d;
  logic [2:0]       row, row_d;
  logic [7:0]       target, target_d, pad_x_d;
  logic [7:0]       target_calc;
  logic [8:0]       step, dec, inc;
  logic             req_l, req_r, accept;

  // Free-running frame divider, independent of enable and engine state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)             div_cnt <= DIV_LOAD;
    else if (div_cnt == '0)  div_cnt <= DIV_LOAD;
    else                     div_cnt <= div_cnt - 1'b1;
  end

  assign frame_tick = (div_cnt == '0);

  assign req_l  = left & ~right;
  assign req_r  = right & ~left;
  assign accept = (state == S_IDLE) & frame_tick & enable;

`ifdef PADDLE_ACCEL_EN
  logic [8:0] acc_step;
  logic [3:0] run_len, run_next;
  logic       last_l, last_r, same_dir;

  // A run continues only while the same single direction is held at accepted ticks.
  assign same_dir = (req_l & last_l) | (req_r & last_r);
  assign step     = same_dir ? acc_step : 9'(STEP);
  assign run_next = same_dir ? run_len + 4'd1 : 4'd1;

  // Step grows by one after every 8 consecutive moving frames, saturating.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_step <= 9'(STEP);
      run_len  <= '0;
      last_l   <= 1'b0;
      last_r   <= 1'b0;
    end else if (accept) begin
      last_l <= req_l;
      last_r <= req_r;
      if (!(req_l | req_r)) begin
        acc_step <= 9'(STEP);
        run_len  <= '0;
      end else if (run_next == 4'd8) begin
        run_len  <= '0;
        acc_step <= (step < 9'(MAX_STEP)) ? step + 9'd1 : step;
      end else begin
        run_len  <= run_next;
        acc_step <= step;
      end
    end
  end
`else
  assign step = 9'(STEP);
`endif

  // Clamped target at 9 bits so neither edge can wrap.
  always_comb begin
    dec = {1'b0, pad_x} - step;
    inc = {1'b0, pad_x} + step;
    if ({1'b0, pad_x} < step) dec = '0;
    if (inc > X_MAX)          inc = X_MAX;
    target_calc = pad_x;
    if (req_l)      target_calc = dec[7:0];
    else if (req_r) target_calc = inc[7:0];
  end

  // Next-state, scan counter and position update.
  always_comb begin
    state_d  = state;
    col_d    = col;
    row_d    = row;
    target_d = target;
    pad_x_d  = pad_x;
    case (state)
      S_INIT: begin
        state_d = S_DRAW;
        pad_x_d = 8'(X_INIT);
        col_d   = '0;
        row_d   = '0;
      end
      S_IDLE: begin
        if (accept && (target_calc != pad_x)) begin
          state_d  = S_ERASE;
          target_d = target_calc;
          col_d    = '0;
          row_d    = '0;
        end
      end
      S_ERASE, S_DRAW: begin
        if (col == COL_LAST) begin
          col_d = '0;
          if (row == ROW_LAST) begin
            row_d   = '0;
            state_d = (state == S_ERASE) ? S_MOVE : S_IDLE;
          end else begin
            row_d = row + 3'd1;
          end
        end else begin
          col_d = col + 8'd1;
        end
      end
      S_MOVE: begin
        pad_x_d = target;
        state_d = S_DRAW;
        col_d   = '0;
        row_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Engine state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_INIT;
      col    <= '0;
      row    <= '0;
      target <= 8'(X_INIT);
      pad_x  <= 8'(X_INIT);
    end else begin
      state  <= state_d;
      col    <= col_d;
      row    <= row_d;
      target <= target_d;
      pad_x  <= pad_x_d;
    end
  end

  // Pixel port is registered from next-state values so each cycle's outputs match that cycle's state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      plot   <= (state_d == S_ERASE) || (state_d == S_DRAW);
      busy   <= (state_d != S_IDLE);
      x      <= pad_x_d + col_d;
      y      <= 7'(Y_POS) + {4'b0000, row_d};
      colour <= (state_d == S_DRAW) ? FG_COLOUR : BG_COLOUR;
    end
  end

endmodule

// File: tb/tb_paddle_engine.sv
// tb_paddle_engine: table-driven and randomized checks of paddle_engine
// against a pixel-list reference model (FRAME_DIV shortened to 100).
module tb_paddle_engine;

  localparam int FDIV = 100;
  localparam int PW   = 16;
  localparam int PH   = 2;
  localparam int XI   = 72;
  localparam int YP   = 110;
  localparam int XMAX = 160 - PW;
  localparam int NPIX = PW * PH;
`ifdef PADDLE_ACCEL_EN
  localparam int RUN30 = 144;
`else
  localparam int RUN30 = XI + 30;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic [7:0] x, pad_x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, frame_tick;

  paddle_engine #(.FRAME_DIV(FDIV)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .left(left), .right(right),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .pad_x(pad_x), .busy(busy), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [17:0] got[$];
  int          busy_cycles = 0;

  always @(negedge clk) begin
    if (plot) got.push_back({x, y, colour});
    if (busy) busy_cycles++;
  end

  // Reference model: paddle position, acceleration run, expected pixel list.
  int          m_pad, m_step, m_run, m_dir, exp_busy;
  logic [17:0] exp_q[$];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic void push_rect(input int px, input logic [2:0] c);
    for (int r = 0; r < PH; r++)
      for (int cc = 0; cc < PW; cc++)
        exp_q.push_back({8'(px + cc), 7'(YP + r), c});
  endfunction

  function automatic void model_reset();
    m_pad = XI; m_step = 1; m_run = 0; m_dir = 0; exp_busy = 0;
    exp_q.delete();
    push_rect(XI, 3'b111);
  endfunction

  function automatic void model_tick(input bit l, input bit r, input bit en);
    int d, s, tgt;
    exp_q.delete();
    exp_busy = 0;
    if (!en) return;
    d = (l && !r) ? -1 : (r && !l) ? 1 : 0;
    s = 1;
`ifdef PADDLE_ACCEL_EN
    if (d == 0) begin
      m_step = 1; m_run = 0; m_dir = 0;
    end else begin
      if (d != m_dir) begin m_step = 1; m_run = 0; end
      s = m_step;
      m_run++;
      m_dir = d;
      if (m_run == 8) begin
        m_run = 0;
        if (m_step < 4) m_step++;
      end
    end
`endif
    tgt = m_pad + d * s;
    if (tgt < 0) tgt = 0;
    if (tgt > XMAX) tgt = XMAX;
    if (tgt != m_pad) begin
      push_rect(m_pad, 3'b000);
      push_rect(tgt, 3'b111);
      exp_busy = 2 * NPIX + 1;
      m_pad = tgt;
    end
  endfunction

  task automatic chk_pixels(input string tag, input int base);
    int n, bad;
    logic [17:0] g, e;
    n = got.size() - base;
    chk({tag, " plots"}, n, exp_q.size());
    if (n == exp_q.size() && n > 0) begin
      bad = -1;
      for (int i = 0; i < n; i++)
        if (bad < 0 && got[base + i] != exp_q[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        g = got[base + bad];
        e = exp_q[bad];
        $display("FAIL %s pixel %0d: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                 tag, bad, g[17:10], g[9:3], g[2:0], e[17:10], e[9:3], e[2:0]);
      end
    end
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (!frame_tick && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " tick"}, int'(frame_tick), 1);
  endtask

  // One frame: hold inputs over the tick, scramble them afterwards, then check the pass.
  task automatic do_frame(input bit l, input bit r, input bit en, input string tag);
    int pbase, bbase;
    @(negedge clk);
    left = l; right = r; enable = en;
    wait_tick(tag);
    pbase = got.size();
    bbase = busy_cycles;
    model_tick(l, r, en);
    @(posedge clk);
    #1;
    left  = 1'($urandom);
    right = 1'($urandom);
    repeat (80) @(negedge clk);
    #1;
    chk_pixels(tag, pbase);
    chk({tag, " busy"}, busy_cycles - bbase, exp_busy);
    chk({tag, " pad_x"}, int'(pad_x), m_pad);
  endtask

  task automatic reset_and_redraw(input string tag);
    int pbase;
    @(negedge clk);
    resetn = 1'b0;
    left = 1'b0; right = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk({tag, " rst x"}, int'(x), 0);
    chk({tag, " rst y"}, int'(y), 0);
    chk({tag, " rst colour"}, int'(colour), 0);
    chk({tag, " rst plot"}, int'(plot), 0);
    chk({tag, " rst busy"}, int'(busy), 0);
    chk({tag, " rst tick"}, int'(frame_tick), 0);
    chk({tag, " rst pad_x"}, int'(pad_x), XI);
    model_reset();
    pbase = got.size();
    @(negedge clk);
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    chk_pixels({tag, " init draw"}, pbase);
    chk({tag, " init pad_x"}, int'(pad_x), XI);
    chk({tag, " init busy"}, int'(busy), 0);
  endtask

  typedef struct {
    bit l;
    bit r;
    bit en;
    int pad;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int pbase, guard;

    tbl[0] = '{l: 1'b0, r: 1'b1, en: 1'b1, pad: 73};
    tbl[1] = '{l: 1'b0, r: 1'b1, en: 1'b1, pad: 74};
    tbl[2] = '{l: 1'b1, r: 1'b0, en: 1'b1, pad: 73};
    tbl[3] = '{l: 1'b1, r: 1'b1, en: 1'b1, pad: 73};
    tbl[4] = '{l: 1'b0, r: 1'b0, en: 1'b1, pad: 73};
    tbl[5] = '{l: 1'b0, r: 1'b1, en: 1'b0, pad: 73};
    tbl[6] = '{l: 1'b1, r: 1'b0, en: 1'b1, pad: 72};
    tbl[7] = '{l: 1'b1, r: 1'b0, en: 1'b0, pad: 72};

    reset_and_redraw("boot");

    for (int i = 0; i < 8; i++) begin
      do_frame(tbl[i].l, tbl[i].r, tbl[i].en, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table pad", i), int'(pad_x), tbl[i].pad);
    end

    // Disabled engine ignores ticks entirely.
    for (int i = 0; i < 5; i++) do_frame(1'b0, 1'b1, 1'b0, "disabled");
    chk("disabled pad", int'(pad_x), XI);

    // Long right run from the reset position, then release and reverse.
    reset_and_redraw("run");
    for (int i = 0; i < 30; i++) do_frame(1'b0, 1'b1, 1'b1, "run right");
    chk("run30 pad", int'(pad_x), RUN30);
    do_frame(1'b0, 1'b0, 1'b1, "release");
    do_frame(1'b1, 1'b0, 1'b1, "first left");
    chk("first left pad", int'(pad_x), RUN30 - 1);

    // Right edge clamp.
    guard = 0;
    while (m_pad != XMAX && guard < 200) begin
      do_frame(1'b0, 1'b1, 1'b1, "to right");
      guard++;
    end
    do_frame(1'b0, 1'b1, 1'b1, "right at limit");
    chk("right limit pad", int'(pad_x), XMAX);

    // Left edge clamp.
    guard = 0;
    while (m_pad != 0 && guard < 200) begin
      do_frame(1'b1, 1'b0, 1'b1, "to left");
      guard++;
    end
    do_frame(1'b1, 1'b0, 1'b1, "left at limit");
    chk("left limit pad", int'(pad_x), 0);

    // Random frames against the model.
    for (int i = 0; i < 120; i++)
      do_frame(1'($urandom), 1'($urandom), ($urandom_range(3) != 0), "random");

    // Reset in the middle of an erase pass.
    do_frame(1'b1, 1'b0, 1'b1, "pre-reset");
    @(negedge clk);
    left = 1'b0; right = 1'b1; enable = 1'b1;
    wait_tick("mid erase");
    @(posedge clk);
    #1;
    right = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid erase plot", int'(plot), 1);
    chk("mid erase colour", int'(colour), 0);
    #2;
    resetn = 1'b0;
    #1;
    chk("abort plot", int'(plot), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort pad_x", int'(pad_x), XI);
    model_reset();
    pbase = got.size();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    chk_pixels("redraw", pbase);
    chk("redraw pad_x", int'(pad_x), XI);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
